// File: rtl/stopwatch_if.sv
// Control/display bundle between the key handling, the stopwatch counter and
// the display source selector.
interface stopwatch_if;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] stopwatchsech;
    logic [3:0] stopwatchsecl;
    logic [3:0] stopwatchmsech;
    logic [3:0] stopwatchmsecl;
    logic       running;
    logic       ovf;

    modport master (
        output start_stop, clear, lap,
        input  stopwatchsech, stopwatchsecl, stopwatchmsech, stopwatchmsecl,
        input  running, ovf
    );

    modport slave (
        input  start_stop, clear, lap,
        output stopwatchsech, stopwatchsecl, stopwatchmsech, stopwatchmsecl,
        output running, ovf
    );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch: TICK_DIV prescaler to a 10 ms tick and SS.CC BCD count with run/pause/clear.
// Optional lap freeze of the displayed value when STOPWATCH_LAP_EN is defined.
module stopwatch_counter #(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic        clk,
    input  logic        rst,
    stopwatch_if.slave  sw
);
    localparam int unsigned   PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Ripple BCD increment over four digits; any out-of-range digit rolls to 0.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    logic          ss_q_r, clr_q_r;
    logic          ss_press_s, clr_press_s;
    logic [1:0]    state_r, state_nx_s;
    logic [PW-1:0] presc_r, presc_nx_s;
    logic [15:0]   cnt_r, cnt_nx_s;
    logic          tick_s, wrap_s;
    logic          running_r, ovf_r;
    logic [15:0]   out_s;

    assign ss_press_s  = sw.start_stop & ~ss_q_r;
    assign clr_press_s = sw.clear & ~clr_q_r;

    // Next-state, prescaler and count; clear overrides both start_stop and tick.
    always_comb begin
        state_nx_s = state_r;
        presc_nx_s = presc_r;
        cnt_nx_s   = cnt_r;
        tick_s     = (state_r == ST_RUN) && (presc_r == PRE_MAX);
        wrap_s     = tick_s && (cnt_r == 16'h9999);
        if (clr_press_s) begin
            state_nx_s = ST_IDLE;
            presc_nx_s = '0;
            cnt_nx_s   = 16'h0000;
        end else begin
            if (state_r == ST_RUN) begin
                if (tick_s) begin
                    presc_nx_s = '0;
                    cnt_nx_s   = bcd_inc(cnt_r);
                end else begin
                    presc_nx_s = presc_r + PW'(1);
                end
            end else begin
                presc_nx_s = presc_r;
            end
            case (state_r)
                ST_IDLE:  state_nx_s = ss_press_s ? ST_RUN   : ST_IDLE;
                ST_RUN:   state_nx_s = ss_press_s ? ST_PAUSE : ST_RUN;
                ST_PAUSE: state_nx_s = ss_press_s ? ST_RUN   : ST_PAUSE;
                default: begin
                    state_nx_s = ST_IDLE;
                    presc_nx_s = '0;
                    cnt_nx_s   = 16'h0000;
                end
            endcase
        end
    end

    // Edge registers, FSM, prescaler, live count and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q_r    <= 1'b0;
            clr_q_r   <= 1'b0;
            state_r   <= ST_IDLE;
            presc_r   <= '0;
            cnt_r     <= 16'h0000;
            running_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            ss_q_r    <= sw.start_stop;
            clr_q_r   <= sw.clear;
            state_r   <= state_nx_s;
            presc_r   <= presc_nx_s;
            cnt_r     <= cnt_nx_s;
            running_r <= (state_nx_s == ST_RUN);
            ovf_r     <= clr_press_s ? 1'b0 : (ovf_r | wrap_s);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_q_r, lap_press_s;
    logic        frz_r, frz_nx_s;
    logic [15:0] disp_r;

    assign lap_press_s = sw.lap & ~lap_q_r;

    // Lap toggle: ignored in IDLE, released by clear.
    always_comb begin
        if (clr_press_s) begin
            frz_nx_s = 1'b0;
        end else if (lap_press_s && (state_r != ST_IDLE)) begin
            frz_nx_s = ~frz_r;
        end else begin
            frz_nx_s = frz_r;
        end
    end

    // Display register tracks the live count except while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q_r <= 1'b0;
            frz_r   <= 1'b0;
            disp_r  <= 16'h0000;
        end else begin
            lap_q_r <= sw.lap;
            frz_r   <= frz_nx_s;
            disp_r  <= frz_nx_s ? disp_r : cnt_nx_s;
        end
    end

    assign out_s = disp_r;
`else
    assign out_s = cnt_r;
`endif

    assign sw.stopwatchsech  = out_s[15:12];
    assign sw.stopwatchsecl  = out_s[11:8];
    assign sw.stopwatchmsech = out_s[7:4];
    assign sw.stopwatchmsecl = out_s[3:0];
    assign sw.running        = running_r;
    assign sw.ovf            = ovf_r;
endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter with TICK_DIV = 4.
module tb_stopwatch_counter;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    stopwatch_if sw_if();

    stopwatch_counter #(.TICK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] dig;
        logic        run;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    function automatic logic [15:0] bcd(input int k);
        return {4'(k / 1000 % 10), 4'(k / 100 % 10), 4'(k / 10 % 10), 4'(k % 10)};
    endfunction

    task automatic push(input int c, input string n, input logic [15:0] d,
                        input logic r, input logic o);
        exp_t x;
        x.cyc = c; x.name = n; x.dig = d; x.run = r; x.ovf = o;
        exp_q.push_back(x);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compare every expectation due at this cycle against the DUT.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            logic [15:0] got;
            e   = exp_q.pop_front();
            got = {sw_if.stopwatchsech, sw_if.stopwatchsecl,
                   sw_if.stopwatchmsech, sw_if.stopwatchmsecl};
            checks++;
            if (e.cyc != cyc || got !== e.dig || sw_if.running !== e.run
                || sw_if.ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s: cyc %0d got digits=%h running=%b ovf=%b, expected cyc %0d digits=%h running=%b ovf=%b",
                         e.name, cyc, got, sw_if.running, sw_if.ovf,
                         e.cyc, e.dig, e.run, e.ovf);
            end
        end
    end

    int r1, c2, r2, p, h, s, r3;

    initial begin
        rst = 1'b1;
        sw_if.start_stop = 1'b0;
        sw_if.clear = 1'b0;
        sw_if.lap = 1'b0;
        push(2, "reset", 16'h0000, 1'b0, 1'b0);
        push(4, "idle_after_reset", 16'h0000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Start from IDLE and run through the full range to the wrap.
        sw_if.start_stop = 1'b1;
        r1 = cyc + 1;
        push(r1,          "run_rises",   16'h0000, 1'b1, 1'b0);
        push(r1 + 3,      "pre_tick",    16'h0000, 1'b1, 1'b0);
        push(r1 + 4,      "first_tick",  16'h0001, 1'b1, 1'b0);
        push(r1 + 36,     "at_00_09",    16'h0009, 1'b1, 1'b0);
        push(r1 + 40,     "at_00_10",    16'h0010, 1'b1, 1'b0);
        push(r1 + 3996,   "at_09_99",    bcd(999), 1'b1, 1'b0);
        push(r1 + 4000,   "at_10_00",    16'h1000, 1'b1, 1'b0);
        push(r1 + 39996,  "at_99_99",    16'h9999, 1'b1, 1'b0);
        push(r1 + 40000,  "wrap_ovf",    16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        wait_cyc(r1 + 40000);
        sw_if.clear = 1'b1;
        push(r1 + 40001, "clear_ovf", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        sw_if.clear = 1'b0;

        // Pause at 00.05 with prescaler 2, resume keeps phase.
        c2 = cyc + 2;
        wait_cyc(c2);
        sw_if.start_stop = 1'b1;
        r2 = c2 + 1;
        push(r2,      "run2_rises", 16'h0000, 1'b1, 1'b0);
        push(r2 + 20, "at_00_05",   16'h0005, 1'b1, 1'b0);
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        wait_cyc(r2 + 22);
        sw_if.start_stop = 1'b1;
        push(r2 + 23,  "pause_enter", 16'h0005, 1'b0, 1'b0);
        push(r2 + 73,  "pause_hold",  16'h0005, 1'b0, 1'b0);
        push(r2 + 122, "pause_100",   16'h0005, 1'b0, 1'b0);
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        p = r2 + 123;
        wait_cyc(p);
        sw_if.start_stop = 1'b1;
        push(p + 1, "resume",       16'h0005, 1'b1, 1'b0);
        push(p + 2, "resume_phase", 16'h0006, 1'b1, 1'b0);
        @(negedge clk);
        sw_if.start_stop = 1'b0;

        // Held start_stop gives a single toggle.
        h = p + 3;
        wait_cyc(h);
        sw_if.start_stop = 1'b1;
        push(h + 1,  "hold_pause", 16'h0006, 1'b0, 1'b0);
        push(h + 10, "hold_mid",   16'h0006, 1'b0, 1'b0);
        push(h + 20, "hold_end",   16'h0006, 1'b0, 1'b0);
        push(h + 21, "hold_after", 16'h0006, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        sw_if.start_stop = 1'b0;

        // Clear and start_stop together in PAUSE: clear wins.
        s = h + 22;
        wait_cyc(s);
        sw_if.start_stop = 1'b1;
        sw_if.clear = 1'b1;
        push(s + 1, "clr_wins",   16'h0000, 1'b0, 1'b0);
        push(s + 5, "clr_stays",  16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        sw_if.clear = 1'b0;

        // Lap freeze (live count when the feature is compiled out).
        wait_cyc(s + 6);
        sw_if.start_stop = 1'b1;
        r3 = cyc + 1;
        push(r3 + 80, "at_00_20", 16'h0020, 1'b1, 1'b0);
        @(negedge clk);
        sw_if.start_stop = 1'b0;
        wait_cyc(r3 + 80);
        sw_if.lap = 1'b1;
`ifdef STOPWATCH_LAP_EN
        push(r3 + 81,  "lap_frozen",     16'h0020, 1'b1, 1'b0);
        push(r3 + 100, "lap_frozen_mid", 16'h0020, 1'b1, 1'b0);
        push(r3 + 128, "lap_frozen_end", 16'h0020, 1'b1, 1'b0);
`else
        push(r3 + 81,  "lap_ignored",     16'h0020, 1'b1, 1'b0);
        push(r3 + 100, "lap_ignored_mid", 16'h0025, 1'b1, 1'b0);
        push(r3 + 128, "lap_ignored_end", 16'h0032, 1'b1, 1'b0);
`endif
        @(negedge clk);
        sw_if.lap = 1'b0;
        wait_cyc(r3 + 128);
        sw_if.lap = 1'b1;
        push(r3 + 129, "lap_release", 16'h0032, 1'b1, 1'b0);
        push(r3 + 132, "lap_live",    16'h0033, 1'b1, 1'b0);
        @(negedge clk);
        sw_if.lap = 1'b0;

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
